// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access unit: size encodings,
// FSM state type, word-address mask and small decode helpers.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Clears the byte offset so the memory always sees a word address.
    localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Halfwords need addr[0]=0; words (and the reserved size) need addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

    // Loads and sub-word stores must fetch the word first; only word stores skip it.
    function automatic logic needs_read(input logic write, input logic [1:0] size);
        return (!write) || (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the word-organised memory port of the
// access unit. resp_error only exists when MISALIGN_CHECK_EN is defined.
// master = MEM-stage / memory side, slave = the access unit.
interface mem_access_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
`ifdef MISALIGN_CHECK_EN
    logic              resp_error;
`endif
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
`ifdef MISALIGN_CHECK_EN
        output resp_error,
`endif
        output req_ready, resp_valid, resp_rdata,
        output mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_read_data,
`ifdef MISALIGN_CHECK_EN
        input  resp_error,
`endif
        input  req_ready, resp_valid, resp_rdata,
        input  mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Little-endian lane selection: extracts and extends a byte/half/word from a
// memory word, and exposes the lane shift and in-place lane mask so the
// store-merge path indexes lanes exactly the same way.
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data,
    output logic [4:0]  lane_shift,
    output logic [31:0] lane_mask
);
    logic [31:0] lane_s;
    logic [31:0] base_mask_s;

    // Lane position: byte uses addr[1:0], half uses addr[1], word is unshifted.
    always_comb begin
        lane_shift  = 5'd0;
        base_mask_s = 32'hFFFF_FFFF;
        case (size)
            SZ_BYTE: begin
                lane_shift  = {offset, 3'b000};
                base_mask_s = 32'h0000_00FF;
            end
            SZ_HALF: begin
                lane_shift  = {offset[1], 4'b0000};
                base_mask_s = 32'h0000_FFFF;
            end
            default: begin
                lane_shift  = 5'd0;
                base_mask_s = 32'hFFFF_FFFF;
            end
        endcase
        lane_mask = base_mask_s << lane_shift;
        lane_s    = word >> lane_shift;
    end

    // Sign or zero extension of the selected lane.
    always_comb begin
        data = lane_s;
        case (size)
            SZ_BYTE: begin
                if (sign_ext) data = {{24{lane_s[7]}}, lane_s[7:0]};
                else          data = {24'h00_0000, lane_s[7:0]};
            end
            SZ_HALF: begin
                if (sign_ext) data = {{16{lane_s[15]}}, lane_s[15:0]};
                else          data = {16'h0000, lane_s[15:0]};
            end
            default: data = lane_s;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator for the MEM stage. Sizes loads/stores, extends load
// data and performs read-modify-write for byte/halfword stores. All outputs
// are registered from the next state. Optional misalignment reporting is
// compiled in with MISALIGN_CHECK_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    state_t            state_r, state_s;
    logic [1:0]        offset_r;
    logic [1:0]        size_r;
    logic              signed_r;
    logic              write_r;
    logic [DATA_W-1:0] wdata_r;
    logic              accept_s;

    logic              req_ready_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r, resp_rdata_s;
    logic [ADDR_W-1:0] mem_address_r, mem_address_s;
    logic [DATA_W-1:0] mem_write_data_r, mem_write_data_s;
    logic              mem_read_r;
    logic              mem_write_r;
`ifdef MISALIGN_CHECK_EN
    logic              resp_error_r, resp_error_s;
`endif

    logic [31:0]       load_data_s;
    logic [4:0]        lane_shift_s;
    logic [31:0]       lane_mask_s;
    logic [31:0]       merge_s;

    load_align u_load_align (
        .word       (bus.mem_read_data),
        .offset     (offset_r),
        .size       (size_r),
        .sign_ext   (signed_r),
        .data       (load_data_s),
        .lane_shift (lane_shift_s),
        .lane_mask  (lane_mask_s)
    );

    // Sub-word store: keep the fetched word, replace only the target lane.
    assign merge_s = (bus.mem_read_data & ~lane_mask_s) | ((wdata_r << lane_shift_s) & lane_mask_s);

    // Next-state and next-output-data decode.
    always_comb begin
        state_s          = state_r;
        accept_s         = 1'b0;
        resp_rdata_s     = resp_rdata_r;
        mem_address_s    = mem_address_r;
        mem_write_data_s = mem_write_data_r;
`ifdef MISALIGN_CHECK_EN
        resp_error_s     = resp_error_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept_s      = 1'b1;
                    mem_address_s = bus.req_addr & WORD_ADDR_MASK;
                    resp_rdata_s  = {DATA_W{1'b0}};
`ifdef MISALIGN_CHECK_EN
                    resp_error_s  = 1'b0;
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        state_s      = ST_RESP;
                        resp_error_s = 1'b1;
                    end else
`endif
                    if (needs_read(bus.req_write, bus.req_size)) begin
                        state_s = ST_RD;
                    end else begin
                        state_s          = ST_WR;
                        mem_write_data_s = bus.req_wdata;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (write_r) begin
                    state_s          = ST_WR;
                    mem_write_data_s = merge_s;
                end else begin
                    state_s      = ST_RESP;
                    resp_rdata_s = load_data_s;
                end
            end
            ST_WR: begin
                state_s      = ST_RESP;
                resp_rdata_s = {DATA_W{1'b0}};
            end
            ST_RESP: begin
                if (bus.resp_ready) state_s = ST_IDLE;
                else                state_s = ST_RESP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State and registered outputs; strobes follow the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            req_ready_r      <= 1'b1;
            resp_valid_r     <= 1'b0;
            resp_rdata_r     <= {DATA_W{1'b0}};
            mem_address_r    <= {ADDR_W{1'b0}};
            mem_write_data_r <= {DATA_W{1'b0}};
            mem_read_r       <= 1'b0;
            mem_write_r      <= 1'b0;
`ifdef MISALIGN_CHECK_EN
            resp_error_r     <= 1'b0;
`endif
        end else begin
            state_r          <= state_s;
            req_ready_r      <= (state_s == ST_IDLE);
            resp_valid_r     <= (state_s == ST_RESP);
            resp_rdata_r     <= resp_rdata_s;
            mem_address_r    <= mem_address_s;
            mem_write_data_r <= mem_write_data_s;
            mem_read_r       <= (state_s == ST_RD);
            mem_write_r      <= (state_s == ST_WR);
`ifdef MISALIGN_CHECK_EN
            resp_error_r     <= resp_error_s;
`endif
        end
    end

    // Request attributes captured at acceptance and held for the transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_r <= 2'b00;
            size_r   <= SZ_BYTE;
            signed_r <= 1'b0;
            write_r  <= 1'b0;
            wdata_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            offset_r <= bus.req_addr[1:0];
            size_r   <= bus.req_size;
            signed_r <= bus.req_signed;
            write_r  <= bus.req_write;
            wdata_r  <= bus.req_wdata;
        end
    end

    assign bus.req_ready      = req_ready_r;
    assign bus.resp_valid     = resp_valid_r;
    assign bus.resp_rdata     = resp_rdata_r;
    assign bus.mem_address    = mem_address_r;
    assign bus.mem_write_data = mem_write_data_r;
    assign bus.mem_read       = mem_read_r;
    assign bus.mem_write      = mem_write_r;
`ifdef MISALIGN_CHECK_EN
    assign bus.resp_error     = resp_error_r;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a reference byte-level memory model
// produces expected responses and write words at issue time; the response
// handshake pops and compares them. Per-transaction strobe counts, strobe
// cycles and latency are also checked.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Device memory (driven by DUT strobes) and independent reference copy.
    logic [31:0] dmem    [0:16383];
    logic [31:0] ref_mem [0:16383];
    logic        pre_we;
    logic [13:0] pre_idx;
    logic [31:0] pre_data;

    assign bus.mem_read_data = dmem[bus.mem_address[15:2]];

    always @(posedge clk) begin
        if (pre_we) dmem[pre_idx] <= pre_data;
        else if (bus.mem_write) dmem[bus.mem_address[15:2]] <= bus.mem_write_data;
    end

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'hDEAD_BEEF;
        return (32'(i) * 32'h0103_0507) ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic exp_mis(input logic [1:0] size, input logic [31:0] addr);
`ifdef MISALIGN_CHECK_EN
        if (size == 2'b00) return 1'b0;
        if (size == 2'b01) return addr[0];
        return addr[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = ref_mem[addr[15:2]];
        case (size)
            2'b00: begin
                b = w[int'(addr[1:0]) * 8 +: 8];
                return sgn ? {{24{b[7]}}, b} : {24'h0, b};
            end
            2'b01: begin
                h = w[int'(addr[1]) * 16 +: 16];
                return sgn ? {{16{h[15]}}, h} : {16'h0, h};
            end
            default: return w;
        endcase
    endfunction

    task automatic ref_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   ref_mem[addr[15:2]][int'(addr[1:0]) * 8 +: 8]  = wdata[7:0];
            2'b01:   ref_mem[addr[15:2]][int'(addr[1]) * 16 +: 16] = wdata[15:0];
            default: ref_mem[addr[15:2]] = wdata;
        endcase
    endtask

    // One complete transaction; stall = cycles resp_ready is held low under resp_valid.
    task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        logic        mis, exp_rd, exp_wr, done;
        logic [31:0] exp_word, aligned;
        int          exp_lat, rd_cnt, wr_cnt, rd_cyc, wr_cyc, first, vcnt;
        exp_t        e, got;
        mis      = exp_mis(size, addr);
        exp_rd   = !mis && (!wr || size == 2'b00 || size == 2'b01);
        exp_wr   = !mis && wr;
        exp_lat  = mis ? 1 : ((exp_rd && exp_wr) ? 3 : 2);
        aligned  = {addr[31:2], 2'b00};
        e.err    = mis;
        e.rdata  = (wr || mis) ? 32'h0 : ref_load(addr, size, sgn);
        exp_word = 32'h0;
        if (exp_wr) begin
            ref_store(addr, size, wdata);
            exp_word = ref_mem[addr[15:2]];
        end
        exp_q.push_back(e);
        rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; wr_cyc = 0; first = 0; vcnt = 0; done = 1'b0;

        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.resp_ready = (stall == 0);
        check_eq("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            if (cyc > 1) @(negedge clk);
            check_eq("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
            if (bus.mem_read) begin
                rd_cnt++; rd_cyc = cyc;
                check_eq("rd_addr", bus.mem_address, aligned);
            end
            if (bus.mem_write) begin
                wr_cnt++; wr_cyc = cyc;
                check_eq("wr_addr", bus.mem_address, aligned);
                check_eq("wr_data", bus.mem_write_data, exp_word);
            end
            check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (bus.resp_valid) begin
                if (first == 0) first = cyc;
                vcnt++;
                if (!bus.resp_ready && vcnt > stall) bus.resp_ready = 1'b1;
                if (bus.resp_ready) begin
                    check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        got = exp_q.pop_front();
                        check_eq("resp_rdata", bus.resp_rdata, got.rdata);
`ifdef MISALIGN_CHECK_EN
                        check_eq("resp_error", 32'(bus.resp_error), 32'(got.err));
`endif
                    end
                    done = 1'b1;
                end
            end
        end
        check_eq("resp_done", 32'(done), 32'd1);
        check_eq("rd_count", 32'(rd_cnt), 32'(exp_rd));
        check_eq("wr_count", 32'(wr_cnt), 32'(exp_wr));
        check_eq("latency", 32'(first), 32'(exp_lat));
        check_eq("valid_cycles", 32'(vcnt), 32'(stall + 1));
        if (exp_rd) check_eq("rd_cycle", 32'(rd_cyc), 32'd1);
        if (exp_wr) check_eq("wr_cycle", 32'(wr_cyc), exp_rd ? 32'd2 : 32'd1);
        @(negedge clk);
        check_eq("req_ready_after", 32'(bus.req_ready), 32'd1);
        check_eq("resp_valid_after", 32'(bus.resp_valid), 32'd0);
        bus.resp_ready = 1'b0;
    endtask

    // Byte store interrupted by reset during its write cycle.
    task automatic reset_in_wr();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0000_0301;
        bus.req_wdata  = 32'h0000_005A;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_eq("rst_rd_phase", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        check_eq("rst_wr_phase", 32'(bus.mem_write), 32'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_wr_drop", 32'(bus.mem_write), 32'd0);
        check_eq("rst_no_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_valid", 32'(bus.resp_valid), 32'd0);
            check_eq("post_rst_ready", 32'(bus.req_ready), 32'd1);
        end
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        pre_we         = 1'b0;
        pre_idx        = 14'd0;
        pre_data       = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b0;

        // Reset values and memory preload (words 0x40..0xCF = bytes 0x100..0x33F).
        @(negedge clk);
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check_eq("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check_eq("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check_eq("rst_mem_address", bus.mem_address, 32'h0);
        check_eq("rst_mem_wdata", bus.mem_write_data, 32'h0);
`ifdef MISALIGN_CHECK_EN
        check_eq("rst_resp_error", 32'(bus.resp_error), 32'd0);
`endif
        for (int i = 64; i < 208; i++) begin
            pre_we      = 1'b1;
            pre_idx     = 14'(i);
            pre_data    = init_word(i);
            ref_mem[i]  = init_word(i);
            @(negedge clk);
        end
        pre_we = 1'b0;
        rst    = 1'b0;
        @(negedge clk);

        // Directed cases.
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0);          // DEADBEEF
        do_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 0);          // FFFFFFDE
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 0);          // 000000DE
        do_req(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 0);          // FFFFDEAD
        do_req(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 1);          // 000000EF
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_1234, 0);  // RMW -> 1234BEEF
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0);
        do_req(1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'hFFFF_FFA5, 0);  // -> 1234A5EF
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 0);
        do_req(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5);  // back-pressure
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 0);
        do_req(1'b0, 2'b11, 1'b1, 32'h0000_0200, 32'h0, 0);          // reserved size = word
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0, 0);          // misaligned word
        do_req(1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_7777, 0);  // misaligned half store

        reset_in_wr();
        do_req(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 0);          // abandoned write left no trace

        // Randomised mix over a small region.
        for (int n = 0; n < 24; n++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   32'h0000_0300 + 32'($urandom_range(0, 63)), $urandom(), $urandom_range(0, 2));
        end

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
